// File: rtl/masked_subbytes_seq.sv
// masked_subbytes_seq: byte-serial masked AES SubBytes sequencer.
// Accepts a 16-byte Boolean-shared state and feeds one shared byte per cycle
// to an external masked forward S-box. It collects the shared results
// SBOX_LATENCY cycles later and presents the full shared state. Shares are
// never combined.
//
// Ports
//   in_clock, in_reset     clock, async active-low reset
//   in_state/in_valid      masked input state (share s at [128s +: 128],
//                          byte k of a share at [8k +: 8]); out_ready high in IDLE
//   out_sbox_a             shared byte to the S-box (share s at [8s +: 8])
//   in_sbox_b              shared S-box result, same layout
//   in_rnd_valid           S-box randomness available this cycle
//   out_rnd_take           randomness consumed (byte issued) this cycle
//   out_state/out_valid    masked SubBytes result; held until in_ready
//
// Build option
//   MASKED_SUBBYTES_IDLE_ZERO_EN: out_sbox_a reads as all-zero shares in
//   every non-issue cycle, and the input register is cleared on entering DONE.
module masked_subbytes_seq #(
    parameter int unsigned NUM_SHARES   = 2,
    parameter int unsigned SBOX_LATENCY = 3
) (
    input  logic                        in_clock,
    input  logic                        in_reset,
    input  logic [16*NUM_SHARES*8-1:0]  in_state,
    input  logic                        in_valid,
    output logic                        out_ready,
    output logic [NUM_SHARES*8-1:0]     out_sbox_a,
    input  logic [NUM_SHARES*8-1:0]     in_sbox_b,
    input  logic                        in_rnd_valid,
    output logic                        out_rnd_take,
    output logic [16*NUM_SHARES*8-1:0]  out_state,
    output logic                        out_valid,
    input  logic                        in_ready
);

    localparam int unsigned SHARE_W   = 128;
    localparam int unsigned STATE_W   = SHARE_W * NUM_SHARES;
    localparam int unsigned LANE_W    = 8 * NUM_SHARES;
    localparam logic [3:0]  LAST_BYTE = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [STATE_W-1:0]        in_reg_q, in_reg_d;
    logic [STATE_W-1:0]        out_state_q, out_state_d;
    logic [LANE_W-1:0]         sbox_a_q, sbox_a_d;
    logic [3:0]                issue_cnt_q, issue_cnt_d;
    logic [3:0]                cap_cnt_q, cap_cnt_d;
    logic [SBOX_LATENCY-1:0]   vld_sr_q, vld_sr_d;
    logic                      out_valid_q, out_valid_d;
    logic                      take;
    logic                      cap_fire;

    // Gather byte k of every share into one lane, shares kept in separate fields.
    function automatic logic [LANE_W-1:0] get_lane(input logic [STATE_W-1:0] st,
                                                   input logic [3:0] k);
        logic [LANE_W-1:0] lane;
        lane = '0;
        for (int unsigned s = 0; s < NUM_SHARES; s++) begin
            lane[8*s +: 8] = st[SHARE_W*s + 8*32'(k) +: 8];
        end
        return lane;
    endfunction

    assign take     = in_rnd_valid && (state_q == ISSUE);
    assign cap_fire = vld_sr_q[SBOX_LATENCY-1];

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        in_reg_d    = in_reg_q;
        out_state_d = out_state_q;
        sbox_a_d    = sbox_a_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        out_valid_d = out_valid_q;
        vld_sr_d    = vld_sr_q << 1;
        vld_sr_d[0] = take;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_reg_d    = in_state;
                    // Preload byte 0 so it is on the S-box port in the first ISSUE cycle.
                    sbox_a_d    = get_lane(in_state, 4'd0);
                    issue_cnt_d = 4'd0;
                    cap_cnt_d   = 4'd0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (take) begin
                    if (issue_cnt_q == LAST_BYTE) begin
                        state_d = DRAIN;
                    end else begin
                        issue_cnt_d = issue_cnt_q + 4'd1;
                        sbox_a_d    = get_lane(in_reg_q, issue_cnt_q + 4'd1);
                    end
                end
            end
            DRAIN: begin
            end
            DONE: begin
                if (in_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture the shared result of the byte issued SBOX_LATENCY cycles ago.
        if (cap_fire) begin
            for (int unsigned s = 0; s < NUM_SHARES; s++) begin
                out_state_d[SHARE_W*s + 8*32'(cap_cnt_q) +: 8] = in_sbox_b[8*s +: 8];
            end
            if (cap_cnt_q == LAST_BYTE) begin
                if (state_q == DRAIN) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
`ifdef MASKED_SUBBYTES_IDLE_ZERO_EN
                    in_reg_d    = '0;
`endif
                end
            end else begin
                cap_cnt_d = cap_cnt_q + 4'd1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q     <= IDLE;
            in_reg_q    <= '0;
            out_state_q <= '0;
            sbox_a_q    <= '0;
            issue_cnt_q <= 4'd0;
            cap_cnt_q   <= 4'd0;
            vld_sr_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_reg_q    <= in_reg_d;
            out_state_q <= out_state_d;
            sbox_a_q    <= sbox_a_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            vld_sr_q    <= vld_sr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_ready    = (state_q == IDLE);
    assign out_rnd_take = take;
    assign out_state    = out_state_q;
    assign out_valid    = out_valid_q;

`ifdef MASKED_SUBBYTES_IDLE_ZERO_EN
    // Registered byte is exposed only while it is actually being issued.
    assign out_sbox_a = take ? sbox_a_q : '0;
`else
    assign out_sbox_a = sbox_a_q;
`endif

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Bench for masked_subbytes_seq with NUM_SHARES = 2, SBOX_LATENCY = 3 and a
// behavioural 3-stage masked S-box (fresh output mask each cycle) in the loop.
module tb_masked_subbytes_seq;

    logic         clk;
    logic         rst_n;
    logic [255:0] in_state;
    logic         in_valid;
    logic         out_ready;
    logic [15:0]  out_sbox_a;
    logic [15:0]  in_sbox_b;
    logic         in_rnd_valid;
    logic         out_rnd_take;
    logic [255:0] out_state;
    logic         out_valid;
    logic         in_ready;

    int n_cmp = 0;
    int n_bad = 0;

    masked_subbytes_seq #(.NUM_SHARES(2), .SBOX_LATENCY(3)) dut (
        .in_clock     (clk),
        .in_reset     (rst_n),
        .in_state     (in_state),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .out_sbox_a   (out_sbox_a),
        .in_sbox_b    (in_sbox_b),
        .in_rnd_valid (in_rnd_valid),
        .out_rnd_take (out_rnd_take),
        .out_state    (out_state),
        .out_valid    (out_valid),
        .in_ready     (in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AES forward S-box, one row per high nibble, entry 0 in the top byte.
    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        row = sbox_rows[x[7:4]];
        return row[8*(15 - 32'(x[3:0])) +: 8];
    endfunction

    // Masked S-box model: result share0 = S(a0^a1)^m, share1 = m, 3 cycles later.
    logic [15:0] p0, p1, p2;
    logic [7:0]  mrnd;
    always @(posedge clk) begin
        mrnd = 8'($urandom);
        p0 <= {mrnd, sbox(out_sbox_a[7:0] ^ out_sbox_a[15:8]) ^ mrnd};
        p1 <= p0;
        p2 <= p1;
    end
    assign in_sbox_b = p2;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] plain;
        logic [127:0] exp;
        bit           masked;
        int           period;
        int           bp;
        int           exp_cyc;
    } vec_t;

    vec_t vecs [4];

    // One block: accept at edge 0, run ISSUE/DRAIN, check the result and handshake.
    task automatic run_block(input vec_t v);
        logic [127:0] mask, sh0, held;
        logic [255:0] inst;
        logic [15:0]  lane;
        int takes, first_take, valid_cyc, drain_chk;
        bit stable;
        mask = v.masked ? {$urandom, $urandom, $urandom, $urandom} : 128'h0;
        sh0  = v.plain ^ mask;
        inst = {mask, sh0};
        @(negedge clk);
        in_state = inst; in_valid = 1'b1; in_ready = 1'b0; in_rnd_valid = 1'b0;
        #1 check("ready_in_idle", 256'(out_ready), 256'(1'b1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        takes = 0; first_take = 0; valid_cyc = 0; drain_chk = 0;
        for (int n = 1; n <= 80 && valid_cyc == 0; n++) begin
            in_rnd_valid = !(v.period != 0 && (n % v.period) == 0);
            #1;
            if (out_valid) begin
                valid_cyc = n;
            end else if (out_rnd_take) begin
                if (takes == 0) first_take = n;
                if (takes < 16) begin
                    lane = {mask[8*takes +: 8], sh0[8*takes +: 8]};
                    check("issue_lane", 256'(out_sbox_a), 256'(lane));
                end
                takes++;
            end else if (takes >= 16 && drain_chk == 0) begin
                drain_chk = 1;
`ifdef MASKED_SUBBYTES_IDLE_ZERO_EN
                check("drain_sbox_a_zero", 256'(out_sbox_a), 256'(16'h0));
`else
                check("drain_sbox_a_hold", 256'(out_sbox_a), 256'({mask[127:120], sh0[127:120]}));
`endif
            end else if (takes > 0 && takes < 16) begin
`ifdef MASKED_SUBBYTES_IDLE_ZERO_EN
                check("bubble_sbox_a_zero", 256'(out_sbox_a), 256'(16'h0));
`endif
            end
            if (valid_cyc == 0) @(negedge clk);
        end
        if (valid_cyc == 0) check("valid_timeout", 256'(1'b0), 256'(1'b1));
        check("take_count", 256'(takes), 256'(16));
        check("first_take_cycle", 256'(first_take), 256'(1));
        check("valid_cycle", 256'(valid_cyc), 256'(v.exp_cyc));
        check("unmasked_out", 256'(out_state[127:0] ^ out_state[255:128]), 256'(v.exp));
        held = out_state[127:0];
        stable = 1'b1;
        for (int i = 0; i < v.bp; i++) begin
            in_valid = 1'b1;
            in_state = ~inst;
            @(negedge clk);
            #1;
            if (out_state[127:0] !== held || out_valid !== 1'b1 || out_ready !== 1'b0
                || out_rnd_take !== 1'b0)
                stable = 1'b0;
        end
        if (v.bp > 0) check("backpressure_stable", 256'(stable), 256'(1'b1));
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("handshake_valid_low", 256'(out_valid), 256'(1'b0));
        check("handshake_ready_high", 256'(out_ready), 256'(1'b1));
        in_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{128'h0, {16{8'h63}}, 1'b0, 0, 0, 20};
        vecs[1] = '{128'h0f0e0d0c0b0a09080706050403020100,
                    128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1, 0, 0, 20};
        vecs[2] = '{128'h0f0e0d0c0b0a09080706050403020100,
                    128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1, 3, 0, 27};
        vecs[3] = '{128'h1f1e1d1c1b1a19181716151413121110,
                    128'hc072a49cafa2d4adf04759fa7dc982ca, 1'b1, 0, 10, 20};

        rst_n = 1'b0; in_state = '0; in_valid = 1'b0; in_rnd_valid = 1'b0; in_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check("rst_out_state", out_state, 256'h0);
        check("rst_out_sbox_a", 256'(out_sbox_a), 256'(16'h0));
        check("rst_out_ready", 256'(out_ready), 256'(1'b1));
        in_rnd_valid = 1'b1;
        #1 check("rst_no_take_idle", 256'(out_rnd_take), 256'(1'b0));
        in_rnd_valid = 1'b0;

        for (int i = 0; i < 4; i++) run_block(vecs[i]);

        // Abort a block with reset in cycle 8; the following block must be clean.
        @(negedge clk);
        in_state = {128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a, 128'h1234567890abcdef0011223344556677};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_rnd_valid = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 256'(out_valid), 256'(1'b0));
        check("midrst_out_state", out_state, 256'h0);
        check("midrst_out_sbox_a", 256'(out_sbox_a), 256'(16'h0));
        check("midrst_out_take", 256'(out_rnd_take), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_after", 256'(out_ready), 256'(1'b1));
        check("midrst_state_after", out_state, 256'h0);
        repeat (4) @(negedge clk);
        #1 check("midrst_no_stale_capture", out_state, 256'h0);
        in_rnd_valid = 1'b0;
        run_block(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
